// File: rtl/johnson_pkg.sv
// Shared definitions for twisted-ring (Johnson) counter blocks.
//   JW    : default ring width
//   PH_W  : phase index width for JW
//   NPH   : number of phases for JW (2*JW)
//   is_johnson(c)    : 1 if c has at most one adjacent-bit transition
//   johnson_phase(c) : phase index 0..NPH-1 of a legal code
package johnson_pkg;

    localparam int unsigned JW   = 6;
    localparam int unsigned PH_W = 4;
    localparam int unsigned NPH  = 2 * JW;

    typedef logic [JW-1:0]   code_t;
    typedef logic [PH_W-1:0] phase_t;

    function automatic logic is_johnson(code_t c);
        int unsigned n;
        n = 0;
        for (int unsigned i = 1; i < JW; i++) begin
            if (c[i] != c[i-1]) n++;
        end
        return (n <= 1);
    endfunction

    // Ones fill from bit0 during the first half-turn and drain from bit0 in the second.
    function automatic phase_t johnson_phase(code_t c);
        int unsigned p;
        p = 0;
        for (int unsigned i = 0; i < JW; i++) begin
            p = p + 32'(c[i]);
        end
        if (c[0] || (c == '0)) return phase_t'(p);
        return phase_t'(NPH - p);
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and phase decode of a Johnson code.
//   code_input   in  WIDTH  ring code (bit0 = feedback end)
//   legal_output out 1      1 if at most one adjacent-bit transition
//   phase_output out PH_W   phase index; meaningful only when legal_output=1
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned PH_W  = 4
) (
    input  logic [WIDTH-1:0] code_input,
    output logic             legal_output,
    output logic [PH_W-1:0]  phase_output
);

    int unsigned trans;
    int unsigned ones;

    always_comb begin
        trans = 0;
        ones  = 0;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            if (code_input[i] != code_input[i-1]) trans++;
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + 32'(code_input[i]);
        end
        legal_output = (trans <= 1);
        if (code_input[0] || (code_input == '0)) begin
            phase_output = PH_W'(ones);
        end else begin
            phase_output = PH_W'(2 * WIDTH - ones);
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registers a Johnson ring code, decodes it to a phase index and one-hot bus,
// and tracks ring health: illegal codes, skipped phases, stalls, revolutions.
//   clk_input          in  clock
//   clr_n_input        in  async active-low reset
//   ring_input         in  Johnson code from upstream ring
//   enable_input       in  1: sample/advance, 0: hold all state
//   err_clear_input    in  clears sticky illegal/skip and disarms successor check
//   phase_output       out registered phase index
//   onehot_output      out one-hot of phase_output, zero until valid
//   phase_valid_output out a legal code has passed both stages
//   rev_count_output   out completed revolutions (wraps)
//   rev_tick_output    out pulse on last->0 phase transition
//   illegal_output     out sticky: non-Johnson code seen
//   skip_output        out sticky: legal non-successor phase seen
//   stall_output       out phase unchanged for STALL_LIMIT enabled cycles
//   reload_req_output  out pulse when illegal_output rises
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH       = JW,
    parameter int unsigned PH_W        = 4,
    parameter int unsigned REV_W       = 8,
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic               clk_input,
    input  logic               clr_n_input,
    input  logic [WIDTH-1:0]   ring_input,
    input  logic               enable_input,
    input  logic               err_clear_input,
    output logic [PH_W-1:0]    phase_output,
    output logic [2*WIDTH-1:0] onehot_output,
    output logic               phase_valid_output,
    output logic [REV_W-1:0]   rev_count_output,
    output logic               rev_tick_output,
    output logic               illegal_output,
    output logic               skip_output,
    output logic               stall_output,
    output logic               reload_req_output
);

    localparam int unsigned NumPh  = 2 * WIDTH;
    localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
    localparam logic [PH_W-1:0] LastPh = PH_W'(NumPh - 1);

    logic [WIDTH-1:0]  s1_code_q;
    logic              s1_vld_q;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              valid_q, valid_d;
    logic              armed_q, armed_d;
    logic [REV_W-1:0]  rev_q, rev_d;
    logic              tick_q, tick_d;
    logic              illegal_q, illegal_d;
    logic              skip_q, skip_d;
    logic              reload_q, reload_d;
    logic [StallW-1:0] stall_cnt_q, stall_cnt_d;

    logic              dec_legal;
    logic [PH_W-1:0]   dec_phase;
    logic [PH_W-1:0]   succ_phase;
    logic              ill_hit;
    logic              skip_hit;

    johnson_code_check #(
        .WIDTH (WIDTH),
        .PH_W  (PH_W)
    ) u_check (
        .code_input   (s1_code_q),
        .legal_output (dec_legal),
        .phase_output (dec_phase)
    );

    assign succ_phase = (phase_q == LastPh) ? '0 : phase_q + PH_W'(1);

    always_comb begin
        phase_d     = phase_q;
        valid_d     = valid_q;
        armed_d     = armed_q;
        rev_d       = rev_q;
        tick_d      = 1'b0;
        reload_d    = 1'b0;
        illegal_d   = illegal_q;
        skip_d      = skip_q;
        stall_cnt_d = stall_cnt_q;
        ill_hit     = 1'b0;
        skip_hit    = 1'b0;

        // Stage 2 only acts once stage 1 holds a real sample.
        if (enable_input && s1_vld_q) begin
            if (!dec_legal) begin
                ill_hit  = 1'b1;
                reload_d = !illegal_q;
            end else begin
                phase_d = dec_phase;
                valid_d = 1'b1;
                armed_d = 1'b1;
                if (armed_q && (dec_phase != phase_q)) begin
                    if (dec_phase == succ_phase) begin
                        if (phase_q == LastPh) begin
                            tick_d = 1'b1;
                            rev_d  = rev_q + REV_W'(1);
                        end
                    end else begin
                        skip_hit = 1'b1;
                    end
                end
            end

            // Illegal codes leave the phase unchanged, so they keep counting.
            if (dec_legal && (dec_phase != phase_q)) begin
                stall_cnt_d = '0;
            end else if (stall_cnt_q < StallW'(STALL_LIMIT)) begin
                stall_cnt_d = stall_cnt_q + StallW'(1);
            end
        end

        if (enable_input) begin
            // A fresh error in the clearing cycle keeps its flag set.
            illegal_d = ill_hit | (illegal_q & ~err_clear_input);
            skip_d    = skip_hit | (skip_q & ~err_clear_input);
            if (err_clear_input) armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk_input or negedge clr_n_input) begin
        if (!clr_n_input) begin
            s1_code_q   <= '0;
            s1_vld_q    <= 1'b0;
            phase_q     <= '0;
            valid_q     <= 1'b0;
            armed_q     <= 1'b0;
            rev_q       <= '0;
            tick_q      <= 1'b0;
            reload_q    <= 1'b0;
            illegal_q   <= 1'b0;
            skip_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (enable_input) begin
                s1_code_q <= ring_input;
                s1_vld_q  <= 1'b1;
            end
            phase_q     <= phase_d;
            valid_q     <= valid_d;
            armed_q     <= armed_d;
            rev_q       <= rev_d;
            tick_q      <= tick_d;
            reload_q    <= reload_d;
            illegal_q   <= illegal_d;
            skip_q      <= skip_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign phase_output       = phase_q;
    assign onehot_output      = valid_q ? ((2*WIDTH)'(1) << phase_q) : '0;
    assign phase_valid_output = valid_q;
    assign rev_count_output   = rev_q;
    assign rev_tick_output    = tick_q;
    assign illegal_output     = illegal_q;
    assign skip_output        = skip_q;
    assign stall_output       = (stall_cnt_q == StallW'(STALL_LIMIT));
    assign reload_req_output  = reload_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: table-driven phase decode plus
// hand-written sequences for revolutions, errors, clearing, stall and reset.
module tb_johnson_phase_decoder;

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [5:0]  ring = '0;
    logic        enable = 1'b0;
    logic        err_clear = 1'b0;
    logic [3:0]  phase;
    logic [11:0] onehot;
    logic        valid;
    logic [7:0]  rev_count;
    logic        rev_tick;
    logic        illegal;
    logic        skip;
    logic        stall;
    logic        reload_req;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic [5:0]  code;
        logic [3:0]  phase;
        logic [11:0] onehot;
    } vec_t;

    vec_t vec[12];

    johnson_phase_decoder u_dut (
        .clk_input          (clk),
        .clr_n_input        (clr_n),
        .ring_input         (ring),
        .enable_input       (enable),
        .err_clear_input    (err_clear),
        .phase_output       (phase),
        .onehot_output      (onehot),
        .phase_valid_output (valid),
        .rev_count_output   (rev_count),
        .rev_tick_output    (rev_tick),
        .illegal_output     (illegal),
        .skip_output        (skip),
        .stall_output       (stall),
        .reload_req_output  (reload_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {2'b0, phase, onehot, valid, rev_count, rev_tick, illegal, skip, stall,
                     reload_req}, 32'h0);
    endtask

    int unsigned n_ticks;
    int unsigned n_bad_ticks;
    logic [3:0]  prev_phase;

    initial begin
        vec[0]  = '{6'b000000, 4'd0,  12'h001};
        vec[1]  = '{6'b000001, 4'd1,  12'h002};
        vec[2]  = '{6'b000011, 4'd2,  12'h004};
        vec[3]  = '{6'b000111, 4'd3,  12'h008};
        vec[4]  = '{6'b001111, 4'd4,  12'h010};
        vec[5]  = '{6'b011111, 4'd5,  12'h020};
        vec[6]  = '{6'b111111, 4'd6,  12'h040};
        vec[7]  = '{6'b111110, 4'd7,  12'h080};
        vec[8]  = '{6'b111100, 4'd8,  12'h100};
        vec[9]  = '{6'b111000, 4'd9,  12'h200};
        vec[10] = '{6'b110000, 4'd10, 12'h400};
        vec[11] = '{6'b100000, 4'd11, 12'h800};

        // Reset state
        #2 clr_n = 1'b0;
        #4 check_all_zero("reset_state");
        #2 clr_n = 1'b1;
        enable = 1'b1;

        // 1: full ring sequence, two-clock latency
        for (int k = 0; k <= 12; k++) begin
            ring = vec[k % 12].code;
            tick();
            if (k == 0) begin
                check("t1_not_valid_yet", {31'b0, valid}, 32'd0);
            end else begin
                check("t1_vec", {7'b0, phase, onehot, valid, illegal, skip, stall, rev_tick,
                                 reload_req},
                      {7'b0, vec[k-1].phase, vec[k-1].onehot, 1'b1, 5'b0});
            end
        end
        check("t1_rev_count", {24'b0, rev_count}, 32'd0);

        // 2: three revolutions
        n_ticks     = 0;
        n_bad_ticks = 0;
        for (int j = 0; j < 36; j++) begin
            ring       = vec[(j + 1) % 12].code;
            prev_phase = phase;
            tick();
            if (rev_tick) begin
                n_ticks++;
                if (!(prev_phase == 4'd11 && phase == 4'd0)) n_bad_ticks++;
            end
        end
        check("t2_tick_count", n_ticks, 32'd3);
        check("t2_tick_position", n_bad_ticks, 32'd0);
        check("t2_rev_count", {24'b0, rev_count}, 32'd3);

        // 3: illegal codes
        ring = vec[1].code;                               // A: decodes 000000
        tick();
        check("t3_wrap_rev", {20'b0, phase, rev_count, 3'b0, rev_tick}, {20'b0, 4'd0, 8'd4, 4'd1});
        ring = 6'b010100;                                 // B: decodes 000001
        tick();
        check("t3_pre_phase", {28'b0, phase}, 32'd1);
        ring = vec[2].code;                               // C: decodes 010100
        tick();
        check("t3_illegal_hit", {24'b0, phase, valid, illegal, reload_req, skip},
              {24'b0, 4'd1, 4'b1110});
        ring = 6'b101101;                                 // D: decodes 000011
        tick();
        check("t3_reload_single", {26'b0, phase, reload_req, illegal}, {26'b0, 4'd2, 2'b01});
        ring = vec[3].code;                               // E: decodes 101101
        tick();
        check("t3_second_illegal", {26'b0, phase, reload_req, illegal}, {26'b0, 4'd2, 2'b01});
        err_clear = 1'b1;                                 // F: decodes 000111 + clear
        tick();
        check("t3_illegal_cleared", {27'b0, phase, illegal}, {27'b0, 4'd3, 1'b0});

        // 4: skip and err_clear priority
        ring = vec[2].code;                               // G: clear again, disarm
        tick();
        err_clear = 1'b0;
        ring = vec[4].code;                               // H: decodes 000011, unarmed
        tick();
        check("t4_rearm_no_skip", {27'b0, phase, skip}, {27'b0, 4'd2, 1'b0});
        tick();                                           // I: decodes 001111, 2->4
        check("t4_skip", {27'b0, phase, skip}, {27'b0, 4'd4, 1'b1});
        ring = vec[7].code;                               // J: decodes 001111 again
        tick();
        err_clear = 1'b1;                                 // K: skip 4->7 with clear
        tick();
        check("t4_skip_wins_clear", {27'b0, phase, skip}, {27'b0, 4'd7, 1'b1});
        tick();                                           // L: clear alone
        check("t4_clear_alone", {27'b0, phase, skip}, {27'b0, 4'd7, 1'b0});
        err_clear = 1'b0;

        // 5: stall detection and enable hold
        ring = vec[3].code;                               // M: decodes 111110, rearms
        tick();
        tick();                                           // N: change to phase 3
        check("t5_phase3", {28'b0, phase}, 32'd3);
        for (int n = 1; n <= 19; n++) begin
            tick();
            check($sformatf("t5_stall_n%0d", n), {31'b0, stall}, {31'b0, n >= 15});
        end
        ring = vec[4].code;
        tick();
        check("t5_stall_before_adv", {31'b0, stall}, 32'd1);
        tick();
        check("t5_stall_released", {27'b0, phase, stall}, {27'b0, 4'd4, 1'b0});
        for (int n = 0; n < 14; n++) tick();
        check("t5_count14", {31'b0, stall}, 32'd0);
        enable = 1'b0;
        ring   = vec[9].code;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("t5_frozen", {25'b0, phase, stall, valid, rev_tick}, {25'b0, 4'd4, 3'b010});
        end
        enable = 1'b1;
        ring   = vec[4].code;
        tick();
        check("t5_resume_stall", {27'b0, phase, stall}, {27'b0, 4'd4, 1'b1});

        // 6: asynchronous reset mid-revolution
        ring = vec[5].code;
        tick();
        ring = vec[6].code;
        tick();
        check("t6_pre_reset", {20'b0, phase, rev_count}, {20'b0, 4'd5, 8'd4});
        #2 clr_n = 1'b0;
        #1 check_all_zero("t6_async_reset");
        #2 clr_n = 1'b1;
        ring = vec[8].code;
        tick();
        check("t6_first_stage_only", {31'b0, valid}, 32'd0);
        tick();
        check("t6_first_legal", {26'b0, phase, valid, skip}, {26'b0, 4'd8, 2'b10});
        ring = vec[9].code;
        tick();
        tick();
        check("t6_successor", {26'b0, phase, skip, illegal}, {26'b0, 4'd9, 2'b00});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
